// File: rtl/rename_tag_ctrl.sv
// Rename tag allocator: in-order circular tag pool with dual allocate, dual commit and WAW-aware RAT writes.
// Optional stall statistics counter enabled by defining RENAME_TAG_STATS_EN.
module rename_tag_ctrl #(
    parameter int NUM_TAGS  = 32,
    parameter int TAG_WIDTH = $clog2(NUM_TAGS),
    parameter int ARCH_REGS = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid_0,
    input  logic                          in_valid_1,
    input  logic                          in_has_rd_0,
    input  logic                          in_has_rd_1,
    input  logic [$clog2(ARCH_REGS)-1:0]  in_rd_0,
    input  logic [$clog2(ARCH_REGS)-1:0]  in_rd_1,
    output logic                          in_ready,
    output logic [TAG_WIDTH-1:0]          out_tag_0,
    output logic [TAG_WIDTH-1:0]          out_tag_1,
    output logic                          rat_we_0,
    output logic                          rat_we_1,
    output logic [$clog2(ARCH_REGS)-1:0]  rat_addr_0,
    output logic [$clog2(ARCH_REGS)-1:0]  rat_addr_1,
    output logic [TAG_WIDTH-1:0]          rat_tag_0,
    output logic [TAG_WIDTH-1:0]          rat_tag_1,
    input  logic                          commit_valid_0,
    input  logic                          commit_valid_1,
    output logic [TAG_WIDTH-1:0]          head_tag,
    output logic [TAG_WIDTH:0]            free_count,
    output logic                          full,
    output logic                          empty,
    output logic [31:0]                   stall_cycles
);

    localparam int RD_W = $clog2(ARCH_REGS);
    localparam int CW   = TAG_WIDTH + 1;

    logic [TAG_WIDTH-1:0] head_q, head_d;
    logic [TAG_WIDTH-1:0] tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;
    logic [CW-1:0]        sum_s;
    logic [1:0]           need_s, alloc_s, freed_s;
    logic                 fire_s, slot1_fire_s;

    // Request sizing, admission and RAT write sequencing.
    always_comb begin
        need_s       = {1'b0, in_valid_0} + {1'b0, in_valid_0 & in_valid_1};
        in_ready     = !flush &&
                       (((CW+1)'(count_q) + (CW+1)'(need_s)) <= (CW+1)'(NUM_TAGS));
        fire_s       = in_valid_0 & in_ready;
        slot1_fire_s = fire_s & in_valid_1;
        if (fire_s) begin
            alloc_s = need_s;
        end else begin
            alloc_s = 2'd0;
        end
        if (flush) begin
            freed_s = 2'd0;
        end else begin
            freed_s = {1'b0, commit_valid_0} + {1'b0, commit_valid_0 & commit_valid_1};
        end
        out_tag_0  = tail_q;
        out_tag_1  = tail_q + TAG_WIDTH'(1);
        // Younger slot owns the RAT entry when both slots write the same rd.
        rat_we_0   = fire_s & in_has_rd_0 & (in_rd_0 != RD_W'(0)) &
                     !(slot1_fire_s & in_has_rd_1 & (in_rd_1 == in_rd_0));
        rat_we_1   = slot1_fire_s & in_has_rd_1 & (in_rd_1 != RD_W'(0));
        rat_addr_0 = in_rd_0;
        rat_addr_1 = in_rd_1;
        rat_tag_0  = out_tag_0;
        rat_tag_1  = out_tag_1;
    end

    // Next-state for the circular pointers and occupancy count.
    always_comb begin
        sum_s = count_q + CW'(alloc_s);
        if (flush) begin
            head_d  = TAG_WIDTH'(0);
            tail_d  = TAG_WIDTH'(0);
            count_d = CW'(0);
        end else begin
            head_d = head_q + TAG_WIDTH'(freed_s);
            tail_d = tail_q + TAG_WIDTH'(alloc_s);
            // Over-commit is illegal; clamp rather than wrap the count.
            if (sum_s < CW'(freed_s)) begin
                count_d = CW'(0);
            end else begin
                count_d = sum_s - CW'(freed_s);
            end
        end
    end

    // Pool state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= TAG_WIDTH'(0);
            tail_q  <= TAG_WIDTH'(0);
            count_q <= CW'(0);
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_tag   = head_q;
    assign free_count = CW'(NUM_TAGS) - count_q;
    assign full       = (count_q == CW'(NUM_TAGS));
    assign empty      = (count_q == CW'(0));

`ifdef RENAME_TAG_STATS_EN
    logic [31:0] stall_q, stall_d;

    // Saturating count of cycles where decode was held off for lack of tags.
    always_comb begin
        if (in_valid_0 && !in_ready && !flush && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // Stall counter register; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 32'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 32'd0;
`endif

    rename_tag_ctrl_chk #(.CW(CW)) u_chk (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .freed_i (freed_s),
        .count_i (count_q)
    );

endmodule

// Protocol checker: commits must never exceed the outstanding tag count.
module rename_tag_ctrl_chk #(
    parameter int CW = 6
) (
    input logic          clk,
    input logic          rst,
    input logic          flush,
    input logic [1:0]    freed_i,
    input logic [CW-1:0] count_i
);

    a_no_overcommit: assert property (@(posedge clk) disable iff (rst || flush)
        (CW'(freed_i) <= count_i));

endmodule

// File: tb/tb_rename_tag_ctrl.sv
// Self-checking bench for rename_tag_ctrl: directed scenarios plus randomized traffic
// checked against a queue-based model of outstanding tags.
module tb_rename_tag_ctrl;

    localparam int NT = 32;
`ifdef RENAME_TAG_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       v0 = 1'b0, v1 = 1'b0, hr0 = 1'b0, hr1 = 1'b0;
    logic [4:0] rd0 = 5'd0, rd1 = 5'd0;
    logic       cv0 = 1'b0, cv1 = 1'b0;
    logic       in_ready, rat_we_0, rat_we_1, full, empty;
    logic [4:0] out_tag_0, out_tag_1, rat_addr_0, rat_addr_1, rat_tag_0, rat_tag_1, head_tag;
    logic [5:0] free_count;
    logic [31:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    // Model: queue of outstanding tags in allocation order, next tag to hand out, stall count.
    int q[$];
    int tail_m = 0;
    longint stall_m = 0;

    always #5 clk = ~clk;

    rename_tag_ctrl dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid_0(v0), .in_valid_1(v1), .in_has_rd_0(hr0), .in_has_rd_1(hr1),
        .in_rd_0(rd0), .in_rd_1(rd1), .in_ready(in_ready),
        .out_tag_0(out_tag_0), .out_tag_1(out_tag_1),
        .rat_we_0(rat_we_0), .rat_we_1(rat_we_1),
        .rat_addr_0(rat_addr_0), .rat_addr_1(rat_addr_1),
        .rat_tag_0(rat_tag_0), .rat_tag_1(rat_tag_1),
        .commit_valid_0(cv0), .commit_valid_1(cv1),
        .head_tag(head_tag), .free_count(free_count), .full(full), .empty(empty),
        .stall_cycles(stall_cycles)
    );

    function automatic int m_need();
        return v0 ? (v1 ? 2 : 1) : 0;
    endfunction

    function automatic bit m_ready();
        return !flush && (q.size() + m_need() <= NT);
    endfunction

    function automatic bit m_we0();
        return m_ready() && v0 && hr0 && rd0 != 0 && !(v1 && hr1 && rd1 == rd0);
    endfunction

    function automatic bit m_we1();
        return m_ready() && v0 && v1 && hr1 && rd1 != 0;
    endfunction

    function automatic int m_head();
        return (q.size() != 0) ? q[0] : tail_m;
    endfunction

    function automatic longint m_stall();
        return STATS ? stall_m : 0;
    endfunction

    task automatic idle();
        v0 = 1'b0; v1 = 1'b0; hr0 = 1'b0; hr1 = 1'b0; rd0 = 5'd0; rd1 = 5'd0;
        cv0 = 1'b0; cv1 = 1'b0; flush = 1'b0;
    endtask

    // One clock edge; the model consumes the inputs that were stable before it.
    task automatic advance();
        bit fire, stall_c;
        int nd, fr;
        fire    = v0 && m_ready();
        stall_c = v0 && !m_ready() && !flush;
        nd      = m_need();
        fr      = cv0 ? (cv1 ? 2 : 1) : 0;
        @(posedge clk);
        if (rst) begin
            q.delete(); tail_m = 0; stall_m = 0;
        end else if (flush) begin
            q.delete(); tail_m = 0;
        end else begin
            repeat (fr) if (q.size() != 0) void'(q.pop_front());
            if (fire) repeat (nd) begin
                q.push_back(tail_m);
                tail_m = (tail_m + 1) % NT;
            end
            if (stall_c && stall_m != 64'hFFFF_FFFF) stall_m++;
        end
        #1;
    endtask

    task automatic do_reset();
        idle(); rst = 1'b1; advance(); rst = 1'b0;
    endtask

    task automatic dual_req(input logic [4:0] a, input logic [4:0] b);
        v0 = 1'b1; v1 = 1'b1; hr0 = 1'b1; hr1 = 1'b1; rd0 = a; rd1 = b;
    endtask

    task automatic test_reset();
        do_reset(); do_reset();
        #1;
        checks++; if (free_count !== 6'd32) begin errors++; $display("FAIL rst_free act=%0d exp=32", free_count); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL rst_flags act=%0b%0b exp=10", empty, full); end
        checks++; if (head_tag !== 5'd0) begin errors++; $display("FAIL rst_head act=%0d exp=0", head_tag); end
        checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL rst_stall act=%0d exp=0", stall_cycles); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready act=%0b exp=1", in_ready); end
    endtask

    task automatic test_dual();
        dual_req(5'd5, 5'd6); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dual_ready act=%0b exp=1", in_ready); end
        checks++; if (out_tag_0 !== 5'd0 || out_tag_1 !== 5'd1) begin errors++; $display("FAIL dual_tags act=%0d/%0d exp=0/1", out_tag_0, out_tag_1); end
        checks++; if (rat_we_0 !== 1'b1 || rat_we_1 !== 1'b1) begin errors++; $display("FAIL dual_we act=%0b%0b exp=11", rat_we_0, rat_we_1); end
        checks++; if (rat_addr_0 !== 5'd5 || rat_addr_1 !== 5'd6) begin errors++; $display("FAIL dual_addr act=%0d/%0d exp=5/6", rat_addr_0, rat_addr_1); end
        checks++; if (rat_tag_0 !== 5'd0 || rat_tag_1 !== 5'd1) begin errors++; $display("FAIL dual_rtag act=%0d/%0d exp=0/1", rat_tag_0, rat_tag_1); end
        advance(); idle(); #1;
        checks++; if (free_count !== 6'd30) begin errors++; $display("FAIL dual_free act=%0d exp=30", free_count); end
    endtask

    task automatic test_waw();
        dual_req(5'd7, 5'd7); #1;
        checks++; if (rat_we_0 !== 1'b0 || rat_we_1 !== 1'b1) begin errors++; $display("FAIL waw_we act=%0b%0b exp=01", rat_we_0, rat_we_1); end
        checks++; if (rat_tag_1 !== 5'd3 || rat_addr_1 !== 5'd7) begin errors++; $display("FAIL waw_tag act=%0d@%0d exp=3@7", rat_tag_1, rat_addr_1); end
        advance(); idle(); #1;
        checks++; if (out_tag_0 !== 5'd4 || free_count !== 6'd28) begin errors++; $display("FAIL waw_adv act=%0d/%0d exp=4/28", out_tag_0, free_count); end
    endtask

    task automatic test_no_rd();
        dual_req(5'd3, 5'd0); hr0 = 1'b0; #1;
        checks++; if (in_ready !== 1'b1 || rat_we_0 !== 1'b0 || rat_we_1 !== 1'b0) begin errors++; $display("FAIL nord_we act=%0b%0b%0b exp=100", in_ready, rat_we_0, rat_we_1); end
        advance(); idle(); #1;
        checks++; if (free_count !== 6'd26 || out_tag_0 !== 5'd6) begin errors++; $display("FAIL nord_adv act=%0d/%0d exp=26/6", free_count, out_tag_0); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        repeat (16) begin dual_req(5'd1, 5'd2); advance(); end
        idle(); #1;
        checks++; if (full !== 1'b1 || free_count !== 6'd0 || empty !== 1'b0) begin errors++; $display("FAIL full_flag act=%0b/%0d exp=1/0", full, free_count); end
        dual_req(5'd1, 5'd2); cv0 = 1'b1; #1;
        checks++; if (in_ready !== 1'b0 || rat_we_0 !== 1'b0 || rat_we_1 !== 1'b0) begin errors++; $display("FAIL full_block act=%0b%0b%0b exp=000", in_ready, rat_we_0, rat_we_1); end
        advance(); idle(); #1;
        checks++; if (free_count !== 6'd1 || head_tag !== 5'd1) begin errors++; $display("FAIL full_commit act=%0d/%0d exp=1/1", free_count, head_tag); end
        v0 = 1'b1; #1;
        checks++; if (in_ready !== 1'b1 || out_tag_0 !== 5'd0) begin errors++; $display("FAIL full_wrap act=%0b/%0d exp=1/0", in_ready, out_tag_0); end
        advance(); idle(); #1;
        checks++; if (full !== 1'b1 || out_tag_0 !== 5'd1) begin errors++; $display("FAIL full_refill act=%0b/%0d exp=1/1", full, out_tag_0); end
    endtask

    task automatic test_wrap_tags();
        do_reset();
        repeat (15) begin dual_req(5'd9, 5'd10); advance(); end
        idle(); v0 = 1'b1; advance(); idle();
        cv0 = 1'b1; cv1 = 1'b1; advance(); #1;
        checks++; if (head_tag !== 5'd2) begin errors++; $display("FAIL wrap_head2 act=%0d exp=2", head_tag); end
        repeat (14) advance();
        idle(); #1;
        checks++; if (head_tag !== 5'd30 || free_count !== 6'd31) begin errors++; $display("FAIL wrap_drain act=%0d/%0d exp=30/31", head_tag, free_count); end
        dual_req(5'd11, 5'd12); #1;
        checks++; if (in_ready !== 1'b1 || out_tag_0 !== 5'd31 || out_tag_1 !== 5'd0) begin errors++; $display("FAIL wrap_tags act=%0b/%0d/%0d exp=1/31/0", in_ready, out_tag_0, out_tag_1); end
        advance(); idle(); cv0 = 1'b1; cv1 = 1'b1; advance(); idle(); #1;
        checks++; if (head_tag !== 5'd0 || free_count !== 6'd31) begin errors++; $display("FAIL wrap_commit act=%0d/%0d exp=0/31", head_tag, free_count); end
    endtask

    task automatic test_flush();
        do_reset();
        repeat (5) begin dual_req(5'd4, 5'd8); advance(); end
        idle(); #1;
        checks++; if (free_count !== 6'd22) begin errors++; $display("FAIL flush_pre act=%0d exp=22", free_count); end
        dual_req(5'd4, 5'd8); flush = 1'b1; cv0 = 1'b1; #1;
        checks++; if (in_ready !== 1'b0 || rat_we_0 !== 1'b0 || rat_we_1 !== 1'b0) begin errors++; $display("FAIL flush_block act=%0b%0b%0b exp=000", in_ready, rat_we_0, rat_we_1); end
        advance(); idle(); #1;
        checks++; if (free_count !== 6'd32 || empty !== 1'b1 || out_tag_0 !== 5'd0 || head_tag !== 5'd0) begin errors++; $display("FAIL flush_post act=%0d/%0b/%0d/%0d exp=32/1/0/0", free_count, empty, out_tag_0, head_tag); end
        repeat (16) begin dual_req(5'd4, 5'd8); advance(); end
        repeat (5) advance();
        idle(); #1;
        checks++; if (stall_cycles !== 32'(STATS * 5)) begin errors++; $display("FAIL stall_cnt act=%0d exp=%0d", stall_cycles, STATS * 5); end
        v0 = 1'b1; flush = 1'b1; advance(); idle(); #1;
        checks++; if (stall_cycles !== 32'(STATS * 5) || free_count !== 6'd32) begin errors++; $display("FAIL stall_keep act=%0d/%0d exp=%0d/32", stall_cycles, free_count, STATS * 5); end
    endtask

    task automatic test_random();
        int c;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            v0 = ($urandom_range(0, 3) != 0); v1 = 1'($urandom_range(0, 1));
            hr0 = 1'($urandom_range(0, 1)); hr1 = 1'($urandom_range(0, 1));
            rd0 = 5'($urandom_range(0, 7)); rd1 = 5'($urandom_range(0, 7));
            flush = ($urandom_range(0, 39) == 0);
            c = $urandom_range(0, 2);
            if (c > q.size()) c = q.size();
            cv0 = (c >= 1); cv1 = (c == 2);
            #1;
            checks++; if (in_ready !== m_ready()) begin errors++; $display("FAIL rnd_ready i=%0d act=%0b exp=%0b", i, in_ready, m_ready()); end
            checks++; if (out_tag_0 !== 5'(tail_m) || out_tag_1 !== 5'((tail_m + 1) % NT)) begin errors++; $display("FAIL rnd_tags i=%0d act=%0d/%0d exp=%0d", i, out_tag_0, out_tag_1, tail_m); end
            checks++; if (rat_we_0 !== m_we0() || rat_we_1 !== m_we1()) begin errors++; $display("FAIL rnd_we i=%0d act=%0b%0b exp=%0b%0b", i, rat_we_0, rat_we_1, m_we0(), m_we1()); end
            checks++; if (rat_addr_0 !== rd0 || rat_addr_1 !== rd1 || rat_tag_0 !== out_tag_0 || rat_tag_1 !== out_tag_1) begin errors++; $display("FAIL rnd_ratport i=%0d act=%0d/%0d exp=%0d/%0d", i, rat_addr_0, rat_addr_1, rd0, rd1); end
            checks++; if (free_count !== 6'(NT - q.size()) || full !== (q.size() == NT) || empty !== (q.size() == 0)) begin errors++; $display("FAIL rnd_count i=%0d act=%0d exp=%0d", i, free_count, NT - q.size()); end
            checks++; if (head_tag !== 5'(m_head())) begin errors++; $display("FAIL rnd_head i=%0d act=%0d exp=%0d", i, head_tag, m_head()); end
            checks++; if (stall_cycles !== 32'(m_stall())) begin errors++; $display("FAIL rnd_stall i=%0d act=%0d exp=%0d", i, stall_cycles, m_stall()); end
            advance();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_dual();
        test_waw();
        test_no_rd();
        test_full_wrap();
        test_wrap_tags();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
